// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the 5-stage MIPS pipeline control blocks.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RELEASE  = 2'd2
  } stall_state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

endpackage : cpu_ctrl_pkg

// File: rtl/stall_wait_counter.sv
// Wait-cycle counter with clear/enable; tc_o flags the last allowed wait cycle.
module stall_wait_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TERMINAL - 1));

endmodule : stall_wait_counter

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, taken-branch and multi-cycle
// data-memory accesses into pipeline-register hold/bubble/flush controls.
module pipeline_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_use_i,
  input  logic branch_taken_i,
  input  logic EXMEM_MemRead_i,
  input  logic EXMEM_MemWrite_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic mem_we_o,
  output logic PC_stall_o,
  output logic IFID_stall_o,
  output logic IFID_flush_o,
  output logic IDEX_hold_o,
  output logic IDEX_bubble_o,
  output logic EXMEM_stall_o,
  output logic MEMWB_bubble_o,
  output logic busy_o,
  output logic timeout_o
);

  stall_state_e state_q, state_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic timeout_q, timeout_d;
  logic memop;
  logic wait_tc;

  assign memop = EXMEM_MemRead_i | EXMEM_MemWrite_i;

  stall_wait_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != ST_WAIT_ACK),
    .en_i  (state_q == ST_WAIT_ACK),
    .tc_o  (wait_tc)
  );

  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    timeout_d      = timeout_q;
    PC_stall_o     = 1'b0;
    IFID_stall_o   = 1'b0;
    IFID_flush_o   = 1'b0;
    IDEX_hold_o    = 1'b0;
    IDEX_bubble_o  = 1'b0;
    EXMEM_stall_o  = 1'b0;
    MEMWB_bubble_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (memop) begin
          PC_stall_o     = 1'b1;
          IFID_stall_o   = 1'b1;
          IDEX_hold_o    = 1'b1;
          EXMEM_stall_o  = 1'b1;
          MEMWB_bubble_o = 1'b1;
          state_d        = ST_WAIT_ACK;
          mem_req_d      = 1'b1;
          mem_we_d       = EXMEM_MemWrite_i;
        end else if (load_use_i) begin
          // a branch depending on the pending load has an invalid outcome
          PC_stall_o    = 1'b1;
          IFID_stall_o  = 1'b1;
          IDEX_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          IFID_flush_o = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        PC_stall_o     = 1'b1;
        IFID_stall_o   = 1'b1;
        IDEX_hold_o    = 1'b1;
        EXMEM_stall_o  = 1'b1;
        MEMWB_bubble_o = 1'b1;
        if (mem_ack_i || wait_tc) begin
          timeout_d = timeout_q | ~mem_ack_i;
          state_d   = ST_RELEASE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      ST_RELEASE: begin
        // EX/MEM still holds the completed access, so its mem flags are stale
        if (load_use_i) begin
          PC_stall_o    = 1'b1;
          IFID_stall_o  = 1'b1;
          IDEX_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          IFID_flush_o = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule : pipeline_stall_ctrl

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized + directed bench for pipeline_stall_ctrl against a transaction-level model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst, lu, br, rd, wr, ack;
  logic mem_req, mem_we, pc_stall, ifid_stall, ifid_flush, idex_hold, idex_bubble;
  logic exmem_stall, memwb_bubble, busy, tmo;

  int tests = 0;
  int fails = 0;

  // model: an access in flight, cycles already spent waiting, release slot pending
  bit m_acc, m_rel, m_req, m_we, m_to;
  int m_waited;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .load_use_i(lu), .branch_taken_i(br),
    .EXMEM_MemRead_i(rd), .EXMEM_MemWrite_i(wr), .mem_ack_i(ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .PC_stall_o(pc_stall),
    .IFID_stall_o(ifid_stall), .IFID_flush_o(ifid_flush), .IDEX_hold_o(idex_hold),
    .IDEX_bubble_o(idex_bubble), .EXMEM_stall_o(exmem_stall),
    .MEMWB_bubble_o(memwb_bubble), .busy_o(busy), .timeout_o(tmo)
  );

  task automatic cmp(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs shortly after the edge, then check all outputs at the falling edge.
  task automatic drive(input bit r, input bit w, input bit l, input bit b,
                       input bit a, input bit rs);
    bit mem_stall, haz, flush;
    rd = r; wr = w; lu = l; br = b; ack = a; rst = rs;
    @(negedge clk);
    mem_stall = m_acc || (!m_rel && (r || w));
    haz       = !mem_stall && l;
    flush     = !mem_stall && !l && b;
    cmp("PC_stall",     pc_stall,     mem_stall || haz);
    cmp("IFID_stall",   ifid_stall,   mem_stall || haz);
    cmp("IFID_flush",   ifid_flush,   flush);
    cmp("IDEX_hold",    idex_hold,    mem_stall);
    cmp("IDEX_bubble",  idex_bubble,  haz);
    cmp("EXMEM_stall",  exmem_stall,  mem_stall);
    cmp("MEMWB_bubble", memwb_bubble, mem_stall);
    cmp("hold_bubble_excl", idex_hold & idex_bubble, 1'b0);
    cmp("mem_req",      mem_req,      m_req);
    if (m_req) cmp("mem_we", mem_we, m_we);
    cmp("busy",         busy,         m_acc || m_rel);
    cmp("timeout",      tmo,          m_to);
  endtask

  // Advance the model across the rising edge using the inputs currently applied.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_acc = 0; m_rel = 0; m_req = 0; m_we = 0; m_to = 0; m_waited = 0;
    end else if (m_acc) begin
      m_waited++;
      if (ack || m_waited == TO) begin
        if (!ack) m_to = 1;
        m_acc = 0; m_rel = 1; m_req = 0;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (rd || wr) begin
      m_acc = 1; m_waited = 0; m_req = 1; m_we = wr;
    end
    #1;
  endtask

  task automatic step(input bit r, input bit w, input bit l, input bit b,
                      input bit a, input bit rs);
    drive(r, w, l, b, a, rs);
    advance();
  endtask

  initial begin
    rst = 1; lu = 0; br = 0; rd = 0; wr = 0; ack = 0;
    m_acc = 0; m_rel = 0; m_req = 0; m_we = 0; m_to = 0; m_waited = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 1);
    // reset state
    drive(0, 0, 0, 0, 0, 0);
    cmp("lit_reset_req", mem_req, 1'b0);
    cmp("lit_reset_busy", busy, 1'b0);
    cmp("lit_reset_to", tmo, 1'b0);
    advance();

    // load, ack in the third WAIT_ACK cycle
    drive(1, 0, 0, 0, 0, 0); cmp("lit_ld_c0_stall", pc_stall, 1'b1); advance();
    drive(1, 0, 0, 0, 0, 0); cmp("lit_ld_c1_req", mem_req, 1'b1); cmp("lit_ld_c1_we", mem_we, 1'b0); advance();
    step(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0); cmp("lit_ld_c3_stall", exmem_stall, 1'b1); advance();
    drive(1, 0, 1, 0, 0, 0);
    cmp("lit_ld_rel_busy", busy, 1'b1); cmp("lit_ld_rel_req", mem_req, 1'b0);
    cmp("lit_ld_rel_hold", idex_hold, 1'b0); cmp("lit_ld_rel_bubble", idex_bubble, 1'b1);
    advance();
    drive(0, 0, 0, 0, 0, 0); cmp("lit_ld_idle_busy", busy, 1'b0); advance();

    // store with same-cycle ack
    step(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 0);
    cmp("lit_st_we", mem_we, 1'b1); cmp("lit_st_wait_bubble", idex_bubble, 1'b0);
    advance();
    drive(0, 0, 0, 0, 0, 0); cmp("lit_st_rel", busy, 1'b1); cmp("lit_st_noto", tmo, 1'b0); advance();

    // timeout after four unanswered WAIT_ACK cycles, then sticky
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(TO); i++) step(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0); cmp("lit_to_set", tmo, 1'b1); cmp("lit_to_req", mem_req, 1'b0); advance();
    step(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0); cmp("lit_to_sticky", tmo, 1'b1); advance();

    // priority in IDLE
    drive(0, 0, 1, 1, 0, 0); cmp("lit_pri_flush", ifid_flush, 1'b0); cmp("lit_pri_bubble", idex_bubble, 1'b1); advance();
    drive(0, 0, 0, 1, 0, 0); cmp("lit_br_flush", ifid_flush, 1'b1); cmp("lit_br_stall", pc_stall, 1'b0); advance();

    // reset for two cycles in the middle of WAIT_ACK, then a late ack
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    cmp("lit_rst_req", mem_req, 1'b0); cmp("lit_rst_busy", busy, 1'b0);
    cmp("lit_rst_to", tmo, 1'b0); cmp("lit_rst_stall", pc_stall, 1'b0);
    advance();
    drive(0, 0, 0, 0, 0, 0); cmp("lit_stray_ack", busy, 1'b0); advance();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 20), ($urandom_range(99) < 15),
           ($urandom_range(99) < 30), ($urandom_range(99) < 30),
           ($urandom_range(99) < 30), ($urandom_range(99) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipeline_stall_ctrl
